decode_stage: RTL and testbench

// - Registered ID pipeline stage between fetch and execute. Decodes RV32I and Zicsr
//   (RV32E via NREGS=16) into common::alu_cmd, common::mem_access_type, op1/op2 and branch target.
// - valid/ready handshake on both sides, 1-cycle latency, full throughput, flush input.
// - Optional busy-bit scoreboard stalls RAW hazards until writeback.

---
 rtl/decode_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Registered RV32I/Zicsr decode stage with valid/ready handshake
//
// Purpose: decodes the instruction offered by fetch into an ALU command, memory
// access type, two operands, destination register and branch/jump target. The
// decoded bundle is registered (1-cycle latency, 1 instruction/cycle throughput).
//
// Configuration macro: DECODE_STAGE_SCOREBOARD_EN
//   defined   - NREGS busy bits stall read-after-write hazards until writeback
//   undefined - no stall; wb_valid/wb_rd are ignored
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         fetch-side handshake
//   in_instr, in_pc           instruction word and its address
//   rs1_addr/rs2_addr         combinational regfile read indices
//   rs1_data/rs2_data         regfile read data
//   csr_data                  CSR read data for in_instr[31:20]
//   out_valid/out_ready       execute-side handshake
//   out_alu_op, out_access    common::alu_cmd, common::mem_access_type
//   out_op1, out_op2          operands
//   out_rd, out_wb_en         destination register and its write enable
//   out_pc4, out_target       pc+4 and branch/jump target
//   out_is_jump, out_illegal  control-flow and illegal-instruction flags
//   flush                     kill held bundle and current input
//   wb_valid, wb_rd           writeback completion (scoreboard only)

package common;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BGE  = 4'd12,
        ALU_BGEU = 4'd13,
        ALU_ANDN = 4'd14,
        ALU_ILL  = 4'd15
    } alu_cmd;

    typedef enum logic [3:0] {
        ACC_NONE = 4'd0,
        ACC_LB   = 4'd1,
        ACC_LH   = 4'd2,
        ACC_LW   = 4'd3,
        ACC_LBU  = 4'd4,
        ACC_LHU  = 4'd5,
        ACC_SB   = 4'd6,
        ACC_SH   = 4'd7,
        ACC_SW   = 4'd8
    } mem_access_type;
endpackage

module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CSR_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] csr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [3:0]      out_access,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic [XLEN-1:0] out_pc4,
    output logic [XLEN-1:0] out_target,
    output logic            out_is_jump,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);
    import common::*;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, uimm;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd_f   = in_instr[11:7];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];

    assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
    assign imm_b = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0});
    assign imm_u = sext32({in_instr[31:12], 12'b0});
    assign imm_j = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0});
    assign uimm  = XLEN'(rs1_f);

    assign rs1_addr = rs1_f;
    assign rs2_addr = rs2_f;

    // Decode results (next-state for the output register)
    logic [3:0]      alu_d, access_d;
    logic [XLEN-1:0] op1_d, op2_d, target_d, pc4_d;
    logic            jump_d, illegal_d, wb_en_d;
    logic            legal, writes_rd, use_rs1, use_rs2, chk_rs1, bad_idx;

    assign pc4_d = in_pc + XLEN'(4);

    always_comb begin
        alu_d     = ALU_ILL;
        access_d  = ACC_NONE;
        op1_d     = '0;
        op2_d     = '0;
        target_d  = '0;
        jump_d    = 1'b0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        chk_rs1   = 1'b0;
        bad_idx   = 1'b0;
        illegal_d = 1'b0;
        wb_en_d   = 1'b0;

        case (opcode)
            OPC_OP: begin
                op1_d = rs1_data; op2_d = rs2_data;
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  alu_d = ALU_ADD;
                        3'b001:  alu_d = ALU_SLL;
                        3'b010:  alu_d = ALU_SLT;
                        3'b011:  alu_d = ALU_SLTU;
                        3'b100:  alu_d = ALU_XOR;
                        3'b101:  alu_d = ALU_SRL;
                        3'b110:  alu_d = ALU_OR;
                        default: alu_d = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin alu_d = ALU_SUB; legal = 1'b1; end
                    if (funct3 == 3'b101) begin alu_d = ALU_SRA; legal = 1'b1; end
                end
            end
            OPC_OP_IMM: begin
                op1_d = rs1_data; op2_d = imm_i;
                use_rs1 = 1'b1; writes_rd = 1'b1;
                case (funct3)
                    3'b000: begin alu_d = ALU_ADD;  legal = 1'b1; end
                    3'b010: begin alu_d = ALU_SLT;  legal = 1'b1; end
                    3'b011: begin alu_d = ALU_SLTU; legal = 1'b1; end
                    3'b100: begin alu_d = ALU_XOR;  legal = 1'b1; end
                    3'b110: begin alu_d = ALU_OR;   legal = 1'b1; end
                    3'b111: begin alu_d = ALU_AND;  legal = 1'b1; end
                    3'b001: begin alu_d = ALU_SLL;  legal = (funct7 == 7'b0000000); end
                    default: begin
                        // Shift amount is imm[4:0]; funct7 selects logical/arith
                        if (funct7 == 7'b0000000) begin alu_d = ALU_SRL; legal = 1'b1; end
                        if (funct7 == 7'b0100000) begin alu_d = ALU_SRA; legal = 1'b1; end
                    end
                endcase
            end
            OPC_LOAD: begin
                op1_d = rs1_data; op2_d = imm_i; alu_d = ALU_ADD;
                use_rs1 = 1'b1; writes_rd = 1'b1; legal = 1'b1;
                case (funct3)
                    3'b000:  access_d = ACC_LB;
                    3'b001:  access_d = ACC_LH;
                    3'b010:  access_d = ACC_LW;
                    3'b100:  access_d = ACC_LBU;
                    3'b101:  access_d = ACC_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                op1_d = rs1_data; op2_d = imm_s; alu_d = ALU_ADD;
                use_rs1 = 1'b1; use_rs2 = 1'b1; legal = 1'b1;
                case (funct3)
                    3'b000:  access_d = ACC_SB;
                    3'b001:  access_d = ACC_SH;
                    3'b010:  access_d = ACC_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                op1_d = rs1_data; op2_d = rs2_data;
                target_d = in_pc + imm_b; jump_d = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; legal = 1'b1;
                // BLT/BLTU reuse the set-less-than commands
                case (funct3)
                    3'b000:  alu_d = ALU_BEQ;
                    3'b001:  alu_d = ALU_BNE;
                    3'b100:  alu_d = ALU_SLT;
                    3'b101:  alu_d = ALU_BGE;
                    3'b110:  alu_d = ALU_SLTU;
                    3'b111:  alu_d = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                op1_d = imm_u; alu_d = ALU_ADD; writes_rd = 1'b1; legal = 1'b1;
            end
            OPC_AUIPC: begin
                op1_d = imm_u; op2_d = in_pc; alu_d = ALU_ADD; writes_rd = 1'b1; legal = 1'b1;
            end
            OPC_JAL: begin
                op1_d = XLEN'(1); alu_d = ALU_ADD; writes_rd = 1'b1; legal = 1'b1;
                target_d = in_pc + imm_j; jump_d = 1'b1;
            end
            OPC_JALR: begin
                op1_d = XLEN'(1); alu_d = ALU_ADD; writes_rd = 1'b1; use_rs1 = 1'b1;
                target_d = (rs1_data + imm_i) & ~XLEN'(1); jump_d = 1'b1;
                legal = (funct3 == 3'b000);
            end
            OPC_MISC_MEM: begin
                // FENCE: a no-op in this in-order pipeline
                alu_d = ALU_ADD; legal = (funct3 == 3'b000);
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK (funct3=0) are delivered as illegal so execute traps
                if (CSR_EN != 0) begin
                    op1_d = csr_data; writes_rd = 1'b1; legal = 1'b1;
                    case (funct3)
                        3'b001: begin alu_d = ALU_ADD; chk_rs1 = 1'b1; end
                        3'b010: begin alu_d = ALU_OR;   op2_d = rs1_data; use_rs1 = 1'b1; end
                        3'b011: begin alu_d = ALU_ANDN; op2_d = rs1_data; use_rs1 = 1'b1; end
                        3'b101: alu_d = ALU_ADD;
                        3'b110: begin alu_d = ALU_OR;   op2_d = uimm; end
                        3'b111: begin alu_d = ALU_ANDN; op2_d = uimm; end
                        default: legal = 1'b0;
                    endcase
                end
            end
            default: legal = 1'b0;
        endcase

        // Register indices beyond NREGS (RV32E) make the encoding illegal
        bad_idx = ((use_rs1 || chk_rs1) && (int'(rs1_f) >= NREGS)) ||
                  (use_rs2 && (int'(rs2_f) >= NREGS)) ||
                  (writes_rd && (int'(rd_f) >= NREGS));

        if (!legal || bad_idx) begin
            alu_d     = ALU_ILL;
            access_d  = ACC_NONE;
            op1_d     = '0;
            op2_d     = '0;
            target_d  = '0;
            jump_d    = 1'b0;
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            illegal_d = 1'b1;
        end else begin
            wb_en_d = writes_rd && (rd_f != 5'd0);
        end
    end

    // Handshake
    logic valid_q;
    logic wb_en_q;
    logic stall, handoff, accept;

    assign handoff  = valid_q && out_ready && !flush;
    assign in_ready = !flush && !stall && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef DECODE_STAGE_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d, set_mask, clr_mask;
    logic             hazard;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        hazard   = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (handoff && wb_en_q && (out_rd == 5'(r))) set_mask[r] = 1'b1;
            if (wb_valid && (wb_rd == 5'(r)))            clr_mask[r] = 1'b1;
        end
        // Set applied after clear so a same-cycle handoff to rd wins
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        // Compare against next-cycle bits: a writeback this cycle releases the
        // stall immediately, a handoff this cycle blocks a dependent follower
        for (int r = 1; r < NREGS; r++) begin
            if (busy_d[r] && ((use_rs1 && (rs1_f == 5'(r))) ||
                              (use_rs2 && (rs2_f == 5'(r)))))
                hazard = 1'b1;
        end
    end

    assign stall = in_valid && hazard;

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd};
    assign stall     = 1'b0;
`endif

    // Output bundle register
    logic [3:0]      alu_q, access_q;
    logic [XLEN-1:0] op1_q, op2_q, pc4_q, target_q;
    logic [4:0]      rd_q;
    logic            jump_q, illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            access_q  <= ACC_NONE;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            pc4_q     <= '0;
            target_q  <= '0;
            jump_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            alu_q     <= alu_d;
            access_q  <= access_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_f;
            wb_en_q   <= wb_en_d;
            pc4_q     <= pc4_d;
            target_q  <= target_d;
            jump_q    <= jump_d;
            illegal_q <= illegal_d;
        end else if (handoff) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_alu_op  = alu_q;
    assign out_access  = access_q;
    assign out_op1     = op1_q;
    assign out_op2     = op2_q;
    assign out_rd      = rd_q;
    assign out_wb_en   = wb_en_q;
    assign out_pc4     = pc4_q;
    assign out_target  = target_q;
    assign out_is_jump = jump_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - Directed self-checking bench for decode_stage
module tb_decode_stage;
    import common::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush, wb_valid;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data, csr_data;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, out_wb_en, out_is_jump, out_illegal;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [3:0]  out_alu_op, out_access;
    logic [31:0] out_op1, out_op2, out_pc4, out_target;

    logic        e_in_ready, e_out_valid, e_out_wb_en, e_out_is_jump, e_out_illegal;
    logic [4:0]  e_rs1_addr, e_rs2_addr, e_out_rd;
    logic [3:0]  e_out_alu_op, e_out_access;
    logic [31:0] e_out_op1, e_out_op2, e_out_pc4, e_out_target;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_data(csr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_access(out_access), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_pc4(out_pc4), .out_target(out_target),
        .out_is_jump(out_is_jump), .out_illegal(out_illegal), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    decode_stage #(.NREGS(16)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_data(csr_data),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_alu_op(e_out_alu_op),
        .out_access(e_out_access), .out_op1(e_out_op1), .out_op2(e_out_op2), .out_rd(e_out_rd),
        .out_wb_en(e_out_wb_en), .out_pc4(e_out_pc4), .out_target(e_out_target),
        .out_is_jump(e_out_is_jump), .out_illegal(e_out_illegal), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One handoff cycle, then write back every register so no busy bit lingers
    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        cycle();
        for (int r = 1; r < 32; r++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(r);
            cycle();
        end
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] addi_x1_x0(input logic [11:0] k);
        return {k, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; in_instr = 32'h0; in_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; csr_data = 32'h0;
        cycle(); cycle();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_access",    out_access, ACC_NONE);
        check("rst_op1",       out_op1, 32'h0);
        check("rst_target",    out_target, 32'h0);
        check("rst_wb_en",     out_wb_en, 1'b0);
        rst = 1'b0;
        cycle();

        // ADDI x1,x2,-1
        rs1_data = 32'd5; rs2_data = 32'd77;
        in_instr = 32'hFFF10093;
        #1;
        check("addi_rs1_addr", rs1_addr, 5'd2);
        send(32'hFFF10093, 32'h40);
        check("addi_valid", out_valid, 1'b1);
        check("addi_alu",   out_alu_op, ALU_ADD);
        check("addi_op1",   out_op1, 32'd5);
        check("addi_op2",   out_op2, 32'hFFFFFFFF);
        check("addi_rd",    out_rd, 5'd1);
        check("addi_wb_en", out_wb_en, 1'b1);
        check("addi_pc4",   out_pc4, 32'h44);
        idle();

        // BEQ x1,x2,-8 at 0x100
        rs1_data = 32'd3; rs2_data = 32'd9;
        send(32'hFE208CE3, 32'h100);
        check("beq_alu",    out_alu_op, ALU_BEQ);
        check("beq_jump",   out_is_jump, 1'b1);
        check("beq_target", out_target, 32'hF8);
        check("beq_pc4",    out_pc4, 32'h104);
        check("beq_wb_en",  out_wb_en, 1'b0);
        check("beq_op2",    out_op2, 32'd9);
        idle();

        // All-zero word
        send(32'h00000000, 32'h8);
        check("zero_illegal", out_illegal, 1'b1);
        check("zero_alu",     out_alu_op, ALU_ILL);
        check("zero_wb_en",   out_wb_en, 1'b0);
        check("zero_access",  out_access, ACC_NONE);
        idle();

        // ADD x17,x1,x2: legal with 32 regs, illegal with 16
        rs1_data = 32'd10; rs2_data = 32'd20;
        send(32'h002088B3, 32'h0);
        check("add17_legal",     out_illegal, 1'b0);
        check("add17_rd",        out_rd, 5'd17);
        check("add17_wb_en",     out_wb_en, 1'b1);
        check("rv32e_illegal",   e_out_illegal, 1'b1);
        check("rv32e_alu",       e_out_alu_op, ALU_ILL);
        check("rv32e_wb_en",     e_out_wb_en, 1'b0);
        idle();

        // LUI x3,0x12345
        send(32'h123451B7, 32'h0);
        check("lui_op1", out_op1, 32'h12345000);
        check("lui_op2", out_op2, 32'h0);
        idle();

        // SW x2,4(x1)
        rs1_data = 32'h1000; rs2_data = 32'hAB;
        send(32'h0020A223, 32'h0);
        check("sw_access", out_access, ACC_SW);
        check("sw_op1",    out_op1, 32'h1000);
        check("sw_op2",    out_op2, 32'd4);
        check("sw_wb_en",  out_wb_en, 1'b0);
        idle();

        // JAL x1,+16 at 0x200
        send(32'h010000EF, 32'h200);
        check("jal_target", out_target, 32'h210);
        check("jal_op1",    out_op1, 32'd1);
        check("jal_jump",   out_is_jump, 1'b1);
        check("jal_wb_en",  out_wb_en, 1'b1);
        idle();

        // CSRRS x4,0x300,x1
        csr_data = 32'h88; rs1_data = 32'h3;
        send(32'h3000A273, 32'h0);
        check("csrrs_alu", out_alu_op, ALU_OR);
        check("csrrs_op1", out_op1, 32'h88);
        check("csrrs_op2", out_op2, 32'h3);
        idle();

        // Backpressure: held bundle stable, then stream 1/cycle
        send(addi_x1_x0(12'd11), 32'h0);
        out_ready = 1'b0;
        in_instr  = addi_x1_x0(12'd22);
        in_valid  = 1'b1;
        #1;
        check("bp_in_ready0", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_op2",   out_op2, 32'd11);
            check("bp_in_ready",   in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        cycle();
        check("bp_s1", out_op2, 32'd22);
        in_instr = addi_x1_x0(12'd33);
        cycle();
        check("bp_s2", out_op2, 32'd33);
        in_instr = addi_x1_x0(12'd44);
        cycle();
        check("bp_s3", out_op2, 32'd44);
        check("bp_s3_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        cycle();
        check("bp_drained", out_valid, 1'b0);
        idle();

        // Flush with held bundle and offered input
        send(addi_x1_x0(12'd5), 32'h0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = {12'd9, 5'd0, 3'b000, 5'd2, 7'b0010011};
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        // ADD x6,x1,x1 must not stall: the flushed ADDI x1 never set busy
        rs1_data = 32'd7;
        in_instr = 32'h00108333;
        in_valid = 1'b1;
        #1;
        check("flush_no_busy", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("flush_next_op1", out_op1, 32'd7);
        idle();

        // LW x5 then dependent ADD x6,x5,x5
        send(32'h0000A283, 32'h0);
        check("lw_access", out_access, ACC_LW);
        in_instr = 32'h00528333;
        in_valid = 1'b1;
        #1;
`ifdef DECODE_STAGE_SCOREBOARD_EN
        check("sb_stall0", in_ready, 1'b0);
        cycle();
        check("sb_stall1", in_ready, 1'b0);
        check("sb_stall_nv", out_valid, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        check("sb_release", in_ready, 1'b1);
        cycle();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        check("sb_accepted", out_valid, 1'b1);
        check("sb_rd", out_rd, 5'd6);
`else
        check("nosb_ready", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("nosb_accepted", out_rd, 5'd6);
`endif
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
